// File: rtl/q_seq_ctrl.sv
// rtl/q_seq_ctrl.sv - Q-matrix unit sequencer: load Givens pairs, start, wait, stream Q out.
module q_seq_ctrl #(
    parameter int SIZE    = 16,
    parameter int NROT    = 3,
    parameter int NELEM   = 9,
    parameter int AW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic            rot_valid,
    output logic            rot_ready,
    input  logic [SIZE-1:0] rot_sin,
    input  logic [SIZE-1:0] rot_cos,
    output logic            q_load,
    output logic [AW-1:0]   q_addr,
    output logic [SIZE-1:0] q_sin,
    output logic [SIZE-1:0] q_cos,
    output logic            q_start,
    input  logic            q_done,
    output logic            q_read,
    input  logic            q_finish,
    input  logic [SIZE-1:0] q_data,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            err
);
    localparam int EW = $clog2(NELEM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, READ, FINISH, ERR} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   pc, pc_n;
    logic [EW-1:0]   ec, ec_n, rc, rc_n;
    logic [TW-1:0]   timer, timer_n;
    logic            rd_d, rd_d_n;
    logic            rot_ready_n, q_load_n, q_start_n, q_read_n;
    logic [AW-1:0]   q_addr_n;
    logic [SIZE-1:0] q_sin_n, q_cos_n, out_data_n;
    logic            out_valid_n, out_last_n, busy_n, err_n;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ec_n        = ec;
        rc_n        = rc;
        timer_n     = timer;
        rot_ready_n = rot_ready;
        q_load_n    = 1'b0;
        q_addr_n    = q_addr;
        q_sin_n     = q_sin;
        q_cos_n     = q_cos;
        q_start_n   = 1'b0;
        q_read_n    = q_read;
        err_n       = err;
        // rd_d marks the cycle in which the Q unit presents read data
        rd_d_n      = q_read;
        out_valid_n = rd_d;
        out_data_n  = rd_d ? q_data : out_data;
        out_last_n  = rd_d && (ec == EW'(NELEM - 1));
        if (rd_d && (ec != EW'(NELEM - 1)))
            ec_n = ec + EW'(1);

        case (state)
            IDLE: begin
                rot_ready_n = 1'b0;
                if (go) begin
                    err_n       = 1'b0;
                    pc_n        = '0;
                    rot_ready_n = 1'b1;
                    state_n     = LOAD;
                end
            end
            LOAD: begin
                if (rot_valid && rot_ready) begin
                    q_sin_n  = rot_sin;
                    q_cos_n  = rot_cos;
                    q_addr_n = pc;
                    q_load_n = 1'b1;
                    if (pc == AW'(NROT - 1)) begin
                        rot_ready_n = 1'b0;
                        state_n     = START;
                    end else begin
                        pc_n = pc + AW'(1);
                    end
                end
            end
            START: begin
                q_start_n = 1'b1;
                timer_n   = '0;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (q_done) begin
                    state_n  = READ;
                    ec_n     = '0;
                    rc_n     = '0;
                    timer_n  = '0;
                    q_read_n = 1'b1;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            READ: begin
                if (q_read) begin
                    if (rc == EW'(NELEM - 1))
                        q_read_n = 1'b0;
                    else
                        rc_n = rc + EW'(1);
                end
                // leave only once the last element has been captured
                if (rd_d && (ec == EW'(NELEM - 1))) begin
                    state_n = FINISH;
                    timer_n = '0;
                end
            end
            FINISH: begin
                q_read_n = 1'b0;
                if (q_finish) begin
                    state_n = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ERR: begin
                err_n       = 1'b1;
                q_read_n    = 1'b0;
                rot_ready_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ec        <= '0;
            rc        <= '0;
            timer     <= '0;
            rd_d      <= 1'b0;
            rot_ready <= 1'b0;
            q_load    <= 1'b0;
            q_addr    <= '0;
            q_sin     <= '0;
            q_cos     <= '0;
            q_start   <= 1'b0;
            q_read    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ec        <= ec_n;
            rc        <= rc_n;
            timer     <= timer_n;
            rd_d      <= rd_d_n;
            rot_ready <= rot_ready_n;
            q_load    <= q_load_n;
            q_addr    <= q_addr_n;
            q_sin     <= q_sin_n;
            q_cos     <= q_cos_n;
            q_start   <= q_start_n;
            q_read    <= q_read_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            err       <= err_n;
        end
    end
endmodule
